// File: rtl/div_32_seq.sv
// Iterative restoring divider: one shift-and-trial-subtract per clock, WIDTH iterations per operation.
// Signed mode divides magnitudes and fixes signs on entry to DONE; divide-by-zero short-cuts straight to DONE.
module div_32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             over,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic             over_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rmd_q;

    logic             dvd_neg_d;
    logic             dvs_neg_d;
    logic [WIDTH-1:0] dvd_mag_d;
    logic [WIDTH-1:0] dvs_mag_d;
    logic             ovf_d;
    logic [WIDTH:0]   shifted_d;
    logic             fits_d;
    logic [WIDTH-1:0] rem_step_d;
    logic [WIDTH-1:0] quo_step_d;
    logic [WIDTH-1:0] quo_fix_d;
    logic [WIDTH-1:0] rem_fix_d;

    always_comb begin
        dvd_neg_d = signed_op & dividend[WIDTH-1];
        dvs_neg_d = signed_op & divisor[WIDTH-1];
        dvd_mag_d = dvd_neg_d ? -dividend : dividend;
        dvs_mag_d = dvs_neg_d ? -divisor : divisor;
        ovf_d     = signed_op && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
    end

    // The shifted partial remainder keeps its top bit: with an unsigned divisor above
    // 2^(WIDTH-1) the remainder can itself have its MSB set before the shift.
    always_comb begin
        shifted_d  = {rem_q, dvd_q[WIDTH-1]};
        fits_d     = shifted_d >= {1'b0, dvs_q};
        rem_step_d = fits_d ? (shifted_d[WIDTH-1:0] - dvs_q) : shifted_d[WIDTH-1:0];
        quo_step_d = {dvd_q[WIDTH-2:0], fits_d};
        quo_fix_d  = neg_quo_q ? -quo_step_d : quo_step_d;
        rem_fix_d  = neg_rem_q ? -rem_step_d : rem_step_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            over_q    <= 1'b0;
            quo_q     <= '0;
            rmd_q     <= '0;
        end else begin
            unique case (state_q)
                CALC: begin
                    // Dividend register doubles as the quotient shift register.
                    rem_q <= rem_step_d;
                    dvd_q <= quo_step_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        quo_q   <= quo_fix_d;
                        rmd_q   <= rem_fix_d;
                        over_q  <= ovf_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    if (start) begin
                        dbz_q  <= 1'b0;
                        over_q <= 1'b0;
                        ovf_q  <= ovf_d;
                        if (divisor == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            dbz_q   <= 1'b1;
                            quo_q   <= '1;
                            rmd_q   <= dividend;
                        end else begin
                            state_q   <= CALC;
                            busy_q    <= 1'b1;
                            dvd_q     <= dvd_mag_d;
                            dvs_q     <= dvs_mag_d;
                            rem_q     <= '0;
                            cnt_q     <= CW'(WIDTH - 1);
                            neg_quo_q <= dvd_neg_d ^ dvs_neg_d;
                            neg_rem_q <= dvd_neg_d;
                        end
                    end
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;
    assign over        = over_q;
    assign dbg_state   = state_q;

    a_busy_done_excl: assert property (@(posedge clk) disable iff (rst) !(busy_q && done_q));
    a_flags_excl:     assert property (@(posedge clk) disable iff (rst) !(dbz_q && over_q));
    a_busy_is_calc:   assert property (@(posedge clk) disable iff (rst) busy_q == (state_q == CALC));

endmodule

// File: tb/tb_div_32_seq.sv
// Scenario-task bench for div_32_seq: expected results are queued when a start is driven
// and popped by a monitor whenever done pulses.
module tb_div_32_seq;

    localparam int W = 32;
    typedef logic [2*W+1:0] exp_t;  // {quotient, remainder, div_by_zero, over}

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         signed_op = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         over;
    logic [1:0]   dbg_state;

    int   n_tests = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    div_32_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .over        (over),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, n_tests=%0d n_fail=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && done) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: got q=%h r=%h with no result outstanding", quotient, remainder);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({quotient, remainder, div_by_zero, over} !== e) begin
                    n_fail++;
                    $display("FAIL result: got q=%h r=%h dbz=%b ov=%b, expected q=%h r=%h dbz=%b ov=%b",
                             quotient, remainder, div_by_zero, over,
                             e[2*W+1:W+2], e[W+1:2], e[1], e[0]);
                end
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic exp_t model(input logic sop, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic   ov;
        if (b == '0) return {{W{1'b1}}, a, 1'b1, 1'b0};
        if (sop) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
            q  = sa / sb;
            r  = sa % sb;
        end
        ov = sop && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        return {q[W-1:0], r[W-1:0], 1'b0, ov};
    endfunction

    // ---------------- driver ----------------
    task automatic do_op(input logic sop, input logic [W-1:0] a, input logic [W-1:0] b,
                         input exp_t e, input string name);
        int   k;
        int   lat;
        logic seen;
        logic busy_bad;
        logic edbz;
        edbz = e[1];
        lat  = edbz ? 1 : W + 1;
        exp_q.push_back(e);
        @(negedge clk);
        signed_op = sop;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        k        = 1;
        seen     = 1'b0;
        busy_bad = 1'b0;
        while (k <= W + 5 && !seen) begin
            if (done) begin
                seen = 1'b1;
                if (busy !== 1'b0) busy_bad = 1'b1;
            end else begin
                if (busy !== (!edbz && k <= W)) busy_bad = 1'b1;
                @(negedge clk);
                k++;
            end
        end
        n_tests++;
        if (!seen || k != lat) begin
            n_fail++;
            $display("FAIL %s latency: done seen=%b at cycle %0d, expected cycle %0d", name, seen, k, lat);
        end
        n_tests++;
        if (busy_bad) begin
            n_fail++;
            $display("FAIL %s busy: busy profile wrong, expected high for cycles 1..%0d", name, edbz ? 0 : W);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_pulse: done=%b one cycle after done, expected 0", name, done);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({busy, done, quotient, remainder, div_by_zero, over, dbg_state} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b q=%h r=%h dbz=%b ov=%b st=%0d, expected all 0",
                     busy, done, quotient, remainder, div_by_zero, over, dbg_state);
        end
        rst = 1'b0;
    endtask

    task automatic test_unsigned_hold();
        do_op(1'b0, 32'd100, 32'd7, {32'd14, 32'd2, 1'b0, 1'b0}, "u100_7");
        repeat (4) @(negedge clk);
        n_tests++;
        if ({quotient, remainder, busy, done, dbg_state} !== {32'd14, 32'd2, 1'b0, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL hold_idle: q=%h r=%h busy=%b done=%b st=%0d, expected q=e r=2 idle",
                     quotient, remainder, busy, done, dbg_state);
        end
    endtask

    task automatic test_signed();
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0}, "s_m7_2");
        do_op(1'b0, 32'hFFFF_FFF9, 32'd2, {32'h7FFF_FFFC, 32'd1, 1'b0, 1'b0}, "u_m7_2");
        do_op(1'b1, 32'd7, 32'hFFFF_FFFE, {32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0}, "s_7_m2");
        do_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, {32'd3, 32'hFFFF_FFFF, 1'b0, 1'b0}, "s_m7_m2");
    endtask

    task automatic test_div_zero();
        do_op(1'b0, 32'd5, 32'd0, {32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0}, "u_dbz");
        do_op(1'b1, 32'd5, 32'd0, {32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0}, "s_dbz");
        do_op(1'b1, 32'h8000_0000, 32'd0, {32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0}, "s_dbz_neg");
    endtask

    task automatic test_overflow();
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0, 1'b0, 1'b1}, "s_ovf");
        do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000, 1'b0, 1'b0}, "u_no_ovf");
    endtask

    task automatic test_boundary();
        do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, {32'd1, 32'd1, 1'b0, 1'b0}, "u_big_div");
        do_op(1'b0, 32'hFFFF_FFFF, 32'd1, {32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0}, "u_by_one");
        do_op(1'b0, 32'd0, 32'd5, {32'd0, 32'd0, 1'b0, 1'b0}, "u_zero_num");
        do_op(1'b0, 32'd3, 32'd9, {32'd0, 32'd3, 1'b0, 1'b0}, "u_small_num");
        do_op(1'b1, 32'h8000_0000, 32'd1, {32'h8000_0000, 32'd0, 1'b0, 1'b0}, "s_minneg_1");
    endtask

    task automatic test_back_to_back();
        int k;
        exp_q.push_back({32'd6, 32'd2, 1'b0, 1'b0});
        @(negedge clk);
        signed_op = 1'b0;
        dividend  = 32'd20;
        divisor   = 32'd3;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k     = 1;
        while (k <= W + 5 && !done) begin
            if (k == 10) begin
                dividend = 32'd9;
                divisor  = 32'd9;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (!done || k != W + 1) begin
            n_fail++;
            $display("FAIL b2b_first_latency: done=%b at cycle %0d, expected cycle %0d", done, k, W + 1);
        end
        exp_q.push_back({32'd1, 32'd0, 1'b0, 1'b0});
        dividend = 32'd9;
        divisor  = 32'd9;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k     = 1;
        n_tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b done=%b after start in done cycle, expected busy=1 done=0", busy, done);
        end
        while (k <= W + 5 && !done) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (!done || k != W + 1) begin
            n_fail++;
            $display("FAIL b2b_second_latency: done=%b at cycle %0d, expected cycle %0d", done, k, W + 1);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n_done;
        @(negedge clk);
        signed_op = 1'b0;
        dividend  = 32'd20;
        divisor   = 32'd3;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({busy, done, quotient, remainder, div_by_zero, over, dbg_state} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: busy=%b done=%b q=%h r=%h dbz=%b ov=%b st=%0d, expected all 0",
                     busy, done, quotient, remainder, div_by_zero, over, dbg_state);
        end
        rst    = 1'b0;
        n_done = 0;
        repeat (W + 8) begin
            @(negedge clk);
            if (done) n_done++;
        end
        n_tests++;
        if (n_done != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_discard: %0d done pulses, busy=%b, expected 0 and 0", n_done, busy);
        end
        do_op(1'b0, 32'd1000, 32'd10, {32'd100, 32'd0, 1'b0, 1'b0}, "after_reset");
    endtask

    task automatic test_random();
        logic         sop;
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 24; i++) begin
            sop = 1'($urandom_range(0, 1));
            a   = $urandom();
            case ($urandom_range(0, 3))
                0:       b = $urandom_range(1, 15);
                1:       b = $urandom();
                2:       b = 32'd0 - $urandom_range(1, 15);
                default: b = (i % 8 == 0) ? 32'd0 : $urandom_range(1, 1000);
            endcase
            do_op(sop, a, b, model(sop, a, b), "random");
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_unsigned_hold();
        test_signed();
        test_div_zero();
        test_overflow();
        test_boundary();
        test_back_to_back();
        test_reset_mid();
        test_random();
        repeat (3) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d results still outstanding, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
